// File: rtl/freq_channel_scheduler_if.sv
// Handshake/config bundle between board inputs, the channel scheduler and the shared counter.
interface freq_channel_scheduler_if #(
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2,
  parameter int BITS     = 12
);
  logic [CHANNELS-1:0] signals_in;
  logic [CHANNELS-1:0] chan_enable;
  logic                hold;
  logic                cfg_we;
  logic [CH_BITS-1:0]  cfg_chan;
  logic [BITS-1:0]     cfg_period;
  logic                meas_done;
  logic                sig_out;
  logic [CH_BITS-1:0]  chan_sel;
  logic [BITS-1:0]     period;
  logic                period_load;
  logic                ctr_reset;
  logic                busy;
  logic                timeout_err;

  modport master (
    output signals_in, chan_enable, hold, cfg_we, cfg_chan, cfg_period, meas_done,
    input  sig_out, chan_sel, period, period_load, ctr_reset, busy, timeout_err
  );

  modport slave (
    input  signals_in, chan_enable, hold, cfg_we, cfg_chan, cfg_period, meas_done,
    output sig_out, chan_sel, period, period_load, ctr_reset, busy, timeout_err
  );
endinterface

// File: rtl/freq_channel_scheduler.sv
// Round-robin scheduler sharing one frequency counter across CHANNELS inputs: each visit
// resets the counter, loads the channel's period, then dwells for DWELL completed windows.
module freq_channel_scheduler #(
  parameter int CHANNELS       = 4,
  parameter int CH_BITS        = 2,
  parameter int BITS           = 12,
  parameter int DEFAULT_PERIOD = 1200,
  parameter int DWELL          = 2,
  parameter int TIMEOUT_SLACK  = 32
) (
  input logic                     clk,
  input logic                     reset,
  freq_channel_scheduler_if.slave sched
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_CTR,
    S_LOAD,
    S_MEASURE,
    S_NEXT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CH_BITS-1:0] r_chan_sel;
  logic [BITS-1:0]    r_period;
  logic [BITS-1:0]    r_period_tbl [CHANNELS];
  logic [BITS:0]      r_timer;
  logic [3:0]         r_win_cnt;
  logic               r_timeout_err;
  logic               r_scan_from_zero;

  logic [CH_BITS-1:0] w_scan_start;
  logic [CH_BITS-1:0] w_scan_idx;
  logic [CH_BITS-1:0] w_scan_ch;
  logic               w_scan_hit;
  logic [3:0]         w_cnt_inc;
  logic [BITS:0]      w_timer_inc;
  logic [BITS:0]      w_limit;
  logic               w_timeout;
  logic               w_take_scan;

  // Scan upward from the channel after the current one; the current channel is tried last.
  always_comb begin
    w_scan_start = r_scan_from_zero ? '0 : r_chan_sel + CH_BITS'(1);
    w_scan_hit   = 1'b0;
    w_scan_ch    = r_chan_sel;
    w_scan_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_scan_idx = w_scan_start + CH_BITS'(i);
      if (sched.chan_enable[w_scan_idx]) begin
        w_scan_hit = 1'b1;
        w_scan_ch  = w_scan_idx;
      end
    end
  end

  assign w_cnt_inc   = (r_win_cnt >= 4'(DWELL)) ? 4'(DWELL) : r_win_cnt + 4'd1;
  assign w_timer_inc = r_timer + (BITS+1)'(1);
  assign w_limit     = {1'b0, r_period} + (BITS+1)'(TIMEOUT_SLACK);
  assign w_take_scan = ((r_state == S_IDLE) || (r_state == S_NEXT)) && w_scan_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:      if (w_scan_hit) w_state_nxt = S_RESET_CTR;
      S_RESET_CTR: w_state_nxt = S_LOAD;
      S_LOAD:      w_state_nxt = S_MEASURE;
      S_MEASURE: begin
        if (sched.meas_done) begin
          if ((w_cnt_inc == 4'(DWELL)) && !sched.hold) w_state_nxt = S_NEXT;
        end else if (w_timer_inc == w_limit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_NEXT;
        end
        if (!sched.chan_enable[r_chan_sel]) w_state_nxt = S_NEXT;
      end
      S_NEXT:      w_state_nxt = w_scan_hit ? S_RESET_CTR : S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_chan_sel       <= '0;
      r_period         <= BITS'(DEFAULT_PERIOD);
      r_timer          <= '0;
      r_win_cnt        <= '0;
      r_timeout_err    <= 1'b0;
      r_scan_from_zero <= 1'b1;
      for (int i = 0; i < CHANNELS; i++) r_period_tbl[i] <= BITS'(DEFAULT_PERIOD);
    end else begin
      r_state <= w_state_nxt;
      if (sched.cfg_we && (sched.cfg_period != '0)) r_period_tbl[sched.cfg_chan] <= sched.cfg_period;
      // Period is captured on entry to RESET_CTR so it is already valid during that cycle.
      if (w_take_scan) begin
        r_chan_sel       <= w_scan_ch;
        r_period         <= r_period_tbl[w_scan_ch];
        r_scan_from_zero <= 1'b0;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if (r_state == S_LOAD) begin
        r_timer   <= '0;
        r_win_cnt <= '0;
      end else if (r_state == S_MEASURE) begin
        if (sched.meas_done) begin
          r_timer   <= '0;
          r_win_cnt <= w_cnt_inc;
        end else begin
          r_timer <= w_timer_inc;
        end
      end
    end
  end

  assign sched.sig_out     = sched.signals_in[r_chan_sel];
  assign sched.chan_sel    = r_chan_sel;
  assign sched.period      = r_period;
  assign sched.ctr_reset   = (r_state == S_RESET_CTR);
  assign sched.period_load = (r_state == S_LOAD);
  assign sched.busy        = (r_state != S_IDLE);
  assign sched.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_freq_channel_scheduler.sv
// Bench for freq_channel_scheduler: emulates the counter's meas_done and checks visits
// against a list-level model of the round-robin / period-register rules.
module tb_freq_channel_scheduler;
  localparam int CH = 4, CHB = 2, BITS = 12, DEF = 1200, DWELL = 2, SLACK = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  freq_channel_scheduler_if #(.CHANNELS(CH), .CH_BITS(CHB), .BITS(BITS)) bus ();

  freq_channel_scheduler #(
    .CHANNELS(CH), .CH_BITS(CHB), .BITS(BITS), .DEFAULT_PERIOD(DEF),
    .DWELL(DWELL), .TIMEOUT_SLACK(SLACK)
  ) dut (.clk(clk), .reset(reset), .sched(bus));

  int total = 0;
  int bad = 0;
  int m_sel;
  bit m_first;
  int m_per [CH];
  int cur_per;
  int visits[$];

  function automatic int exp_next(int cur, bit first, logic [CH-1:0] mask);
    int start;
    start = first ? 0 : (cur + 1) % CH;
    for (int i = 0; i < CH; i++)
      if (mask[(start + i) % CH]) return (start + i) % CH;
    return -1;
  endfunction

  task automatic model_reset();
    m_sel = 0;
    m_first = 1'b1;
    for (int i = 0; i < CH; i++) m_per[i] = DEF;
  endtask

  task automatic cfg_write(input int ch, input int val);
    bus.cfg_we = 1'b1;
    bus.cfg_chan = CHB'(ch);
    bus.cfg_period = BITS'(val);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    if (val != 0) m_per[ch] = val;
  endtask

  // Waits for the next ctr_reset and checks the RESET_CTR and LOAD cycles of the visit.
  task automatic visit_start(input bit strict, input string tag);
    int exp, waited;
    bit seen;
    exp = exp_next(m_sel, m_first, bus.chan_enable);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 200) begin
      @(negedge clk);
      waited++;
      if (bus.ctr_reset === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || (strict && waited != 1) || exp < 0) begin
      bad++;
      $display("FAIL %s ctr_reset arrival: seen=%0b after %0d cycles, required seen=1 after %0s (exp ch %0d)",
               tag, seen, waited, strict ? "1" : "<=200", exp);
    end
    if (exp < 0) exp = 0;
    total++;
    if (bus.chan_sel !== CHB'(exp) || bus.period !== BITS'(m_per[exp]) || bus.busy !== 1'b1 ||
        bus.period_load !== 1'b0 || bus.sig_out !== bus.signals_in[exp]) begin
      bad++;
      $display("FAIL %s reset_ctr cycle: chan_sel=%0d period=%0d busy=%b pl=%b sig=%b, required %0d %0d 1 0 %b",
               tag, bus.chan_sel, bus.period, bus.busy, bus.period_load, bus.sig_out,
               exp, m_per[exp], bus.signals_in[exp]);
    end
    m_sel = exp;
    m_first = 1'b0;
    cur_per = m_per[exp];
    visits.push_back(exp);
    @(negedge clk);
    total++;
    if (bus.period_load !== 1'b1 || bus.ctr_reset !== 1'b0 || bus.chan_sel !== CHB'(exp)) begin
      bad++;
      $display("FAIL %s load cycle: pl=%b cr=%b chan_sel=%0d, required 1 0 %0d",
               tag, bus.period_load, bus.ctr_reset, bus.chan_sel, exp);
    end
  endtask

  // Emulates n counter windows, each finishing after a random delay; outputs must hold steady.
  task automatic windows(input int n, input int dmin, input int dmax, input bit leave,
                         input bit rand_sig, input string tag);
    for (int w = 0; w < n; w++) begin
      int d;
      bit glitch;
      d = $urandom_range(dmax, dmin);
      glitch = 1'b0;
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        if (bus.ctr_reset !== 1'b0 || bus.period_load !== 1'b0 || bus.chan_sel !== CHB'(m_sel) ||
            bus.period !== BITS'(cur_per) || bus.sig_out !== bus.signals_in[m_sel]) glitch = 1'b1;
        if (rand_sig) bus.signals_in = CH'($urandom);
      end
      total++;
      if (glitch) begin
        bad++;
        $display("FAIL %s window %0d: outputs moved mid-window, required ch %0d period %0d steady",
                 tag, w, m_sel, cur_per);
      end
      bus.meas_done = 1'b1;
      @(negedge clk);
      bus.meas_done = 1'b0;
    end
    if (leave) begin
      total++;
      if (bus.busy !== 1'b1 || bus.ctr_reset !== 1'b0 || bus.period_load !== 1'b0) begin
        bad++;
        $display("FAIL %s next cycle: busy=%b cr=%b pl=%b, required 1 0 0",
                 tag, bus.busy, bus.ctr_reset, bus.period_load);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    total++;
    if (bus.chan_sel !== 2'd0 || bus.period !== 12'd1200 || bus.period_load !== 1'b0 ||
        bus.ctr_reset !== 1'b0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL reset values: sel=%0d per=%0d pl=%b cr=%b busy=%b terr=%b, required 0 1200 0 0 0 0",
               bus.chan_sel, bus.period, bus.period_load, bus.ctr_reset, bus.busy, bus.timeout_err);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.ctr_reset !== 1'b0) begin
      bad++;
      $display("FAIL idle no enables: busy=%b cr=%b, required 0 0", bus.busy, bus.ctr_reset);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [8];
    bit seq_bad;
    exp_seq = '{0, 1, 2, 3, 0, 2, 0, 2};
    for (int c = 0; c < CH; c++) cfg_write(c, 20);
    bus.chan_enable = 4'b1111;
    visit_start(1'b0, "rr");
    windows(DWELL, 25, 25, 1'b1, 1'b0, "rr");
    for (int v = 1; v < 4; v++) begin
      visit_start(1'b1, "rr");
      windows(DWELL, 25, 25, 1'b1, 1'b0, "rr");
    end
    visit_start(1'b1, "rr");
    bus.chan_enable = 4'b0101;
    windows(DWELL, 25, 25, 1'b1, 1'b0, "rr");
    for (int v = 0; v < 3; v++) begin
      visit_start(1'b1, "alt");
      windows(DWELL, 25, 25, 1'b1, 1'b1, "alt");
    end
    seq_bad = (visits.size() < 8);
    for (int i = 0; i < 8 && i < visits.size(); i++) if (visits[i] != exp_seq[i]) seq_bad = 1'b1;
    total++;
    if (seq_bad) begin
      bad++;
      $display("FAIL visit order: got %p, required 0 1 2 3 0 2 0 2", visits);
    end
  endtask

  task automatic test_cfg_write();
    visit_start(1'b1, "cfg");
    bus.chan_enable = 4'b1111;
    windows(DWELL, 10, 30, 1'b1, 1'b0, "cfg");
    visit_start(1'b1, "cfg");
    @(negedge clk);
    cfg_write(1, 500);
    cfg_write(3, 0);
    windows(DWELL, 10, 30, 1'b1, 1'b0, "cfg_hold_old");
    for (int v = 0; v < 4; v++) begin
      visit_start(1'b1, "cfg_visit");
      windows(DWELL, 10, 30, 1'b1, 1'b0, "cfg");
    end
    total++;
    if (visits[visits.size()-1] != 1 || m_per[1] != 500 || m_per[3] != 20) begin
      bad++;
      $display("FAIL cfg sequence: last ch %0d per1 %0d per3 %0d, required 1 500 20",
               visits[visits.size()-1], m_per[1], m_per[3]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [CH-1:0] mask;
      visit_start(1'b1, "rnd");
      mask = CH'($urandom) | CH'(1 << m_sel);
      bus.chan_enable = mask;
      @(negedge clk);
      if ($urandom_range(1, 0) == 1)
        cfg_write($urandom_range(CH-1, 0), ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(60, 10));
      windows(DWELL, 2, cur_per + 20, 1'b1, 1'b1, "rnd");
    end
  endtask

  task automatic test_timeout();
    bit early;
    bus.chan_enable = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < CH; c++) cfg_write(c, 20);
    bus.chan_enable = 4'b1111;
    visit_start(1'b0, "to");
    early = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      if (bus.timeout_err !== 1'b0 || bus.ctr_reset !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++;
      $display("FAIL timeout early: err/ctr_reset rose before 52 cycles, required 0 until then");
    end
    @(negedge clk);
    total++;
    if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b1 || bus.ctr_reset !== 1'b0) begin
      bad++;
      $display("FAIL timeout rise: err=%b busy=%b cr=%b, required 1 1 0",
               bus.timeout_err, bus.busy, bus.ctr_reset);
    end
    visit_start(1'b1, "to_adv");
    windows(DWELL, 10, 30, 1'b1, 1'b0, "to");
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout sticky: err=%b, required 1", bus.timeout_err);
    end
  endtask

  task automatic test_hold();
    visit_start(1'b1, "hold");
    bus.hold = 1'b1;
    windows(5, 15, 30, 1'b0, 1'b1, "hold");
    bus.hold = 1'b0;
    windows(1, 15, 30, 1'b1, 1'b0, "unhold");
    visit_start(1'b1, "unhold");
  endtask

  task automatic test_drop_enable();
    bit moved;
    repeat (5) @(negedge clk);
    bus.chan_enable = '0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.ctr_reset !== 1'b0) begin
      bad++;
      $display("FAIL drop next: busy=%b cr=%b, required 1 0", bus.busy, bus.ctr_reset);
    end
    moved = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.ctr_reset !== 1'b0 || bus.chan_sel !== CHB'(m_sel)) moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++;
      $display("FAIL drop idle: busy=%b cr=%b sel=%0d, required 0 0 %0d",
               bus.busy, bus.ctr_reset, bus.chan_sel, m_sel);
    end
  endtask

  task automatic test_reset_mid_load();
    bus.chan_enable = 4'b0010;
    visit_start(1'b1, "rst_load");
    bus.chan_enable = 4'b1111;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.period_load !== 1'b0 || bus.ctr_reset !== 1'b0 || bus.busy !== 1'b0 ||
        bus.chan_sel !== 2'd0 || bus.period !== 12'd1200 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL reset mid-load: pl=%b cr=%b busy=%b sel=%0d per=%0d terr=%b, required 0 0 0 0 1200 0",
               bus.period_load, bus.ctr_reset, bus.busy, bus.chan_sel, bus.period, bus.timeout_err);
    end
    reset = 1'b0;
    model_reset();
    visit_start(1'b1, "post_reset");
    bus.chan_enable = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.signals_in = 4'b0110;
    bus.chan_enable = '0;
    bus.hold = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_chan = '0;
    bus.cfg_period = '0;
    bus.meas_done = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_cfg_write();
    test_random();
    test_timeout();
    test_hold();
    test_drop_enable();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
